// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the MEM-stage load/store unit and the data memory
// port. The unit is the master: it drives the request, direction, word
// address, byte enables and write data. The memory side returns the
// completion strobe and the read word.
//
// Signals:
//   dbus_req    master->slave  request, held until ack or timeout
//   dbus_we     master->slave  1 = write
//   dbus_addr   master->slave  word-aligned byte address
//   dbus_be     master->slave  byte enables
//   dbus_wdata  master->slave  lane-replicated store data
//   dbus_ack    slave->master  completion, read data valid in same cycle
//   dbus_rdata  slave->master  read word
interface mem_access_unit_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit. Turns MemRead/MemWrite + funct3 + the ALU
// byte address into one word-aligned data-bus transaction (req/ack), with
// byte enables and replicated store lanes, and returns a sign/zero-extended
// load result. The pipeline is stalled while the access is in flight.
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   mem_cntl_memread        load in MEM stage
//   mem_cntl_memwrite       store in MEM stage (wins over memread)
//   mem_funct[2:0]          000 B, 001 H, 010 W, 100 BU, 101 HU (x1x = W)
//   mem_alu_result[31:0]    effective byte address
//   mem_write_mem_data      store data
//   stall_o                 hold upstream pipeline registers (combinational)
//   rdata_o                 extended load data, held until next load completes
//   rdata_valid_o           1-cycle pulse, load finished
//   misalign_o              1-cycle pulse, misaligned access rejected
//   bus_err_o               1-cycle pulse, access timed out
//   dbus                    data-bus master port
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_cntl_memread,
  input  logic        mem_cntl_memwrite,
  input  logic [2:0]  mem_funct,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_mem_data,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  mem_access_unit_if.master dbus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       funct_q, funct_d;
  logic [1:0]       alo_q, alo_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic             misal_q, misal_d;
  logic             err_q, err_d;

  // Decode of the incoming request
  logic        op, is_w, is_h, misalign;
  logic [1:0]  alo;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;

  assign op   = mem_cntl_memread | mem_cntl_memwrite;
  assign alo  = mem_alu_result[1:0];
  // funct3[1] set means word for every encoding, including the unused 011/110/111
  assign is_w = mem_funct[1];
  assign is_h = ~mem_funct[1] & mem_funct[0];
  assign misalign = (is_h & alo[0]) | (is_w & (alo != 2'b00));

  always_comb begin
    be_new    = 4'b0001 << alo;
    wdata_new = {4{mem_write_mem_data[7:0]}};
    if (is_w) begin
      be_new    = 4'b1111;
      wdata_new = mem_write_mem_data;
    end else if (is_h) begin
      be_new    = 4'b0011 << alo;
      wdata_new = {2{mem_write_mem_data[15:0]}};
    end
    // Reads always fetch the full word; lane selection happens on return
    if (!mem_cntl_memwrite) begin
      be_new = 4'b1111;
    end
  end

  // Load extraction uses the latched size/sign and low address bits
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign ld_byte = dbus.dbus_rdata[{alo_q, 3'b000} +: 8];
  assign ld_half = dbus.dbus_rdata[{alo_q[1], 4'b0000} +: 16];

  always_comb begin
    if (funct_q[1]) begin
      ld_ext = dbus.dbus_rdata;
    end else if (funct_q[0]) begin
      ld_ext = funct_q[2] ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
    end else begin
      ld_ext = funct_q[2] ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    funct_d = funct_q;
    alo_d   = alo_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    misal_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (op && !misalign) begin
          addr_d  = {mem_alu_result[31:2], 2'b00};
          we_d    = mem_cntl_memwrite;
          be_d    = be_new;
          wdata_d = wdata_new;
          funct_d = mem_funct;
          alo_d   = alo;
          cnt_d   = '0;
          state_d = ACCESS;
        end else if (op) begin
          misal_d = 1'b1;
        end
      end
      ACCESS: begin
        // Ack wins over a timeout landing in the same cycle
        if (dbus.dbus_ack) begin
          valid_d = ~we_q;
          if (!we_q) begin
            rdata_d = ld_ext;
          end
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Inputs still present the finished op here; it must not be reissued
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      funct_q <= '0;
      alo_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      misal_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      funct_q <= funct_d;
      alo_q   <= alo_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      misal_q <= misal_d;
      err_q   <= err_d;
    end
  end

  // Request decoded straight from the state register so it drops the
  // moment reset is asserted
  assign dbus.dbus_req   = (state_q == ACCESS);
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_be    = be_q;
  assign dbus.dbus_wdata = wdata_q;

  assign stall_o       = ((state_q == IDLE) & op & ~misalign) | (state_q == ACCESS);
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = valid_q;
  assign misalign_o    = misal_q;
  assign bus_err_o     = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_cntl_memread;
  logic        mem_cntl_memwrite;
  logic [2:0]  mem_funct;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_write_mem_data;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        misalign_o;
  logic        bus_err_o;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(15)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .mem_cntl_memread   (mem_cntl_memread),
    .mem_cntl_memwrite  (mem_cntl_memwrite),
    .mem_funct          (mem_funct),
    .mem_alu_result     (mem_alu_result),
    .mem_write_mem_data (mem_write_mem_data),
    .stall_o            (stall_o),
    .rdata_o            (rdata_o),
    .rdata_valid_o      (rdata_valid_o),
    .misalign_o         (misalign_o),
    .bus_err_o          (bus_err_o),
    .dbus               (bus.master)
  );

  always #5 clk = ~clk;

  // kind: 0 load ok, 1 store ok, 2 misaligned, 3 bus error
  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pulse_code(input int kind);
    case (kind)
      0:       return 32'h4;
      3:       return 32'h2;
      2:       return 32'h1;
      default: return 32'h0;
    endcase
  endfunction

  // Pops the scoreboard whenever any pulse output is seen
  task automatic check_pulses();
    logic [31:0] code;
    exp_t e;
    code = {29'b0, rdata_valid_o, bus_err_o, misalign_o};
    if (code != 0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", code, 32'h0);
      end else begin
        e = sbq.pop_front();
        chk({e.tag, "_pulse"}, code, pulse_code(e.kind));
        if (e.kind == 0 || e.kind == 3) chk({e.tag, "_rdata"}, rdata_o, e.rdata);
        $display("txn %s kind=%0d pulse=%h rdata_o=%h", e.tag, e.kind, code, rdata_o);
      end
    end
  endtask

  // Call at a falling edge with the unit idle. ack_cyc = ACCESS cycle that
  // gets the ack (0 = never).
  task automatic run_op(input string tag, input bit rd, input bit wr,
                        input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                        input int ack_cyc, input logic [31:0] rdat, input int kind,
                        input int exp_stall, input int exp_req,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    int stall_n = 0;
    int req_n = 0;
    int n = 0;
    bit done = 0;
    exp_t e;
    if (kind != 1) begin
      e.tag = tag; e.kind = kind; e.rdata = (kind == 3) ? 32'h0 : exp_rdata;
      sbq.push_back(e);
      if (kind == 0) last_rdata = exp_rdata;
      if (kind == 3) last_rdata = 32'h0;
    end
    mem_cntl_memread = rd; mem_cntl_memwrite = wr; mem_funct = f;
    mem_alu_result = a; mem_write_mem_data = d;
    while (!done && n < 64) begin
      #1;
      if (stall_o) stall_n++;
      if (bus.dbus_req) begin
        req_n++;
        if (req_n == 1) begin
          chk({tag, "_addr"}, bus.dbus_addr, exp_addr);
          chk({tag, "_be"}, {28'b0, bus.dbus_be}, {28'b0, exp_be});
          chk({tag, "_we"}, {31'b0, bus.dbus_we}, {31'b0, wr});
          if (wr) chk({tag, "_wdata"}, bus.dbus_wdata, exp_wdata);
        end
        bus.dbus_ack   = (req_n == ack_cyc);
        bus.dbus_rdata = bus.dbus_ack ? rdat : $urandom;
      end else begin
        bus.dbus_ack = 1'b0;
      end
      check_pulses();
      if (!stall_o) done = 1;
      @(negedge clk);
      n++;
    end
    chk({tag, "_finished"}, {31'b0, done}, 32'h1);
    mem_cntl_memread = 0; mem_cntl_memwrite = 0; bus.dbus_ack = 0;
    #1;
    check_pulses();
    chk({tag, "_no_restart_req"}, {31'b0, bus.dbus_req}, 32'h0);
    chk({tag, "_no_restart_stall"}, {31'b0, stall_o}, 32'h0);
    @(negedge clk);
    #1;
    check_pulses();
    chk({tag, "_stall_cycles"}, stall_n, exp_stall);
    chk({tag, "_req_cycles"}, req_n, exp_req);
    chk({tag, "_sb_empty"}, sbq.size(), 0);
    chk({tag, "_rdata_hold"}, rdata_o, last_rdata);
    $display("txn %s stall=%0d req=%0d rdata_o=%h", tag, stall_n, req_n, rdata_o);
    sbq.delete();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0;
    mem_cntl_memread = 0; mem_cntl_memwrite = 0; mem_funct = 0;
    mem_alu_result = 0; mem_write_mem_data = 0;
    bus.dbus_ack = 0; bus.dbus_rdata = 0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_req", {31'b0, bus.dbus_req}, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_outs", {rdata_o[28:0], rdata_valid_o, misalign_o, bus_err_o}, 32'h0);
    chk("rst_bus", bus.dbus_addr | bus.dbus_wdata | {28'b0, bus.dbus_be}, 32'h0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);

    //      tag      rd wr f       addr          data          ack rdata         kind st rq addr          be       wdata         rdata
    run_op("LW",     1, 0, 3'b010, 32'h0000_0100, 32'h0,        2, 32'hDEADBEEF, 0,   3, 2, 32'h0000_0100, 4'hF,   32'h0,        32'hDEADBEEF);
    run_op("LB",     1, 0, 3'b000, 32'h0000_0203, 32'h0,        1, 32'h80123456, 0,   2, 1, 32'h0000_0200, 4'hF,   32'h0,        32'hFFFFFF80);
    run_op("LBU",    1, 0, 3'b100, 32'h0000_0203, 32'h0,        1, 32'h80123456, 0,   2, 1, 32'h0000_0200, 4'hF,   32'h0,        32'h00000080);
    run_op("LHU",    1, 0, 3'b101, 32'h0000_0202, 32'h0,        1, 32'h80123456, 0,   2, 1, 32'h0000_0200, 4'hF,   32'h0,        32'h00008012);
    run_op("LH",     1, 0, 3'b001, 32'h0000_0202, 32'h0,        1, 32'h80123456, 0,   2, 1, 32'h0000_0200, 4'hF,   32'h0,        32'hFFFF8012);
    run_op("LB1",    1, 0, 3'b000, 32'h0000_0201, 32'h0,        3, 32'h80123456, 0,   4, 3, 32'h0000_0200, 4'hF,   32'h0,        32'h00000034);
    run_op("LHU0",   1, 0, 3'b101, 32'h0000_0204, 32'h0,        1, 32'h1234F00D, 0,   2, 1, 32'h0000_0204, 4'hF,   32'h0,        32'h0000F00D);
    run_op("SH",     0, 1, 3'b001, 32'h0000_0302, 32'h0000ABCD, 1, 32'h0,        1,   2, 1, 32'h0000_0300, 4'b1100, 32'hABCDABCD, 32'h0);
    run_op("SB",     0, 1, 3'b000, 32'h0000_0101, 32'h123456EF, 2, 32'h0,        1,   3, 2, 32'h0000_0100, 4'b0010, 32'hEFEFEFEF, 32'h0);
    run_op("SW_PRI", 1, 1, 3'b010, 32'h0000_0104, 32'hCAFEF00D, 1, 32'h0,        1,   2, 1, 32'h0000_0104, 4'hF,   32'hCAFEF00D, 32'h0);
    run_op("LW011",  1, 0, 3'b011, 32'h0000_0108, 32'h0,        1, 32'h55AA55AA, 0,   2, 1, 32'h0000_0108, 4'hF,   32'h0,        32'h55AA55AA);
    run_op("MIS_LW", 1, 0, 3'b010, 32'h0000_1001, 32'h0,        1, 32'h0,        2,   0, 0, 32'h0,         4'h0,   32'h0,        32'h0);
    run_op("MIS_LH", 1, 0, 3'b001, 32'h0000_0203, 32'h0,        1, 32'h0,        2,   0, 0, 32'h0,         4'h0,   32'h0,        32'h0);
    run_op("MIS_SW", 0, 1, 3'b010, 32'h0000_0106, 32'h1,        1, 32'h0,        2,   0, 0, 32'h0,         4'h0,   32'h0,        32'h0);
    run_op("TMO",    1, 0, 3'b010, 32'h0000_0400, 32'h0,        0, 32'h0,        3,  16, 15, 32'h0000_0400, 4'hF,   32'h0,        32'h0);
    run_op("ACK_LAST",1,0, 3'b010, 32'h0000_0404, 32'h0,       15, 32'h11223344, 0,  16, 15, 32'h0000_0404, 4'hF,   32'h0,        32'h11223344);

    // Ack while idle must be ignored
    bus.dbus_ack = 1; bus.dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk); @(negedge clk);
    #1;
    chk("idle_ack_req", {31'b0, bus.dbus_req}, 32'h0);
    chk("idle_ack_outs", {29'b0, rdata_valid_o, bus_err_o, misalign_o}, 32'h0);
    chk("idle_ack_rdata", rdata_o, last_rdata);
    $display("txn IDLE_ACK req=%b rdata_o=%h", bus.dbus_req, rdata_o);
    bus.dbus_ack = 0;
    @(negedge clk);

    // Async reset in the middle of an access
    mem_cntl_memread = 1; mem_funct = 3'b010; mem_alu_result = 32'h0000_0500;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_mid_req_before", {31'b0, bus.dbus_req}, 32'h1);
    mem_cntl_memread = 0;
    reset_n = 0;
    #1;
    chk("rst_mid_req", {31'b0, bus.dbus_req}, 32'h0);
    chk("rst_mid_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_mid_rdata", rdata_o, 32'h0);
    $display("txn RST_MID req=%b stall=%b", bus.dbus_req, stall_o);
    last_rdata = 32'h0;
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    run_op("LW_POST",1, 0, 3'b010, 32'h0000_0600, 32'h0,        1, 32'hA5A5_0001, 0,  2, 1, 32'h0000_0600, 4'hF,   32'h0,        32'hA5A50001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
